// File: rtl/audio_i2s_serializer_pkg.sv
// Shared types for the I2S serializer: FSM state encoding and the {L,R} word layout.
package audio_i2s_serializer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CH_W   = WORD_W / 2;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Left channel in the upper half, right channel in the lower half.
  typedef struct packed {
    logic [CH_W-1:0] left;
    logic [CH_W-1:0] right;
  } stereo_word_t;

  function automatic logic [CH_W-1:0] chan_sample(input stereo_word_t w, input logic is_right);
    return is_right ? w.right : w.left;
  endfunction

endpackage

// File: rtl/audio_i2s_serializer_bclk_gen.sv
// BCLK generator: clock divider, BCLK register and falling-edge strobe.
// Idle (counter cleared, BCLK low) whenever run_i is low.
module audio_i2s_serializer_bclk_gen #(
  parameter int unsigned pBclkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic bclk_o,
  output logic fall_tick_o_c
);

  localparam int unsigned DIV_W = (pBclkDiv > 1) ? $clog2(pBclkDiv) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(pBclkDiv - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc_c;

  assign tc_c          = (div_cnt_q == DIV_LAST);
  assign fall_tick_o_c = run_i && tc_c && bclk_q;
  assign bclk_o        = bclk_q;

  // Divider advance and BCLK toggle at terminal count.
  always_comb begin
    div_cnt_d = '0;
    bclk_d    = 1'b0;
    if (run_i) begin
      div_cnt_d = tc_c ? '0 : div_cnt_q + DIV_W'(1);
      bclk_d    = tc_c ? ~bclk_q : bclk_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/audio_i2s_serializer.sv
// Serializes {L,R} stereo words to an I2S DAC (BCLK/LRCK/SDATA), one word per frame.
// Build option I2S_LEFT_JUSTIFY_EN selects left-justified framing instead of standard I2S.
module audio_i2s_serializer
  import audio_i2s_serializer_pkg::*;
#(
  parameter int unsigned pBclkDiv   = 4,
  parameter int unsigned pSlotBit   = 32,
  parameter int unsigned pSampleBit = 16
) (
  input  logic              iAudioClk,
  input  logic              iAudioRst,
  input  logic              iEnable,
  input  logic [WORD_W-1:0] iAudioData,
  input  logic              iAudioVd,
  output logic              oAudioReq,
  output logic              oAudioLRch,
  output logic              oI2sBclk,
  output logic              oI2sLrck,
  output logic              oI2sSdata,
  output logic              oUnderrun,
  input  logic              iUnderrunClr
);

  localparam int unsigned FRAME_BITS = 2 * pSlotBit;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(pSlotBit);
  localparam logic [CNT_W-1:0] CNT_SMP  = CNT_W'(pSampleBit);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  stereo_word_t     shadow_q, shadow_d;
  logic             req_q, req_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic             undr_q, undr_d;
  logic             run_c, fall_tick_c, frame_wrap_c, bclk;

  assign run_c        = (state_q == ST_RUN);
  assign frame_wrap_c = fall_tick_c && (bit_cnt_q == CNT_LAST);

  audio_i2s_serializer_bclk_gen #(
    .pBclkDiv (pBclkDiv)
  ) u_bclk_gen (
    .clk_i         (iAudioClk),
    .rst_ni        (iAudioRst),
    .run_i         (run_c),
    .bclk_o        (bclk),
    .fall_tick_o_c (fall_tick_c)
  );

  // Serial bit for a given frame position; zero outside the sample window.
  function automatic logic slot_bit(input stereo_word_t w, input logic [CNT_W-1:0] cnt);
    logic            is_right;
    logic [CNT_W-1:0] b;
    logic [CH_W-1:0] smp;
    logic [CH_W-1:0] shifted;
    int unsigned     sh;
    is_right = (cnt >= CNT_SLOT);
    b        = is_right ? cnt - CNT_SLOT : cnt;
    smp      = chan_sample(w, is_right);
    slot_bit = 1'b0;
`ifdef I2S_LEFT_JUSTIFY_EN
    sh = pSampleBit - 32'(1) - 32'(b);
    shifted = smp >> sh;
    if (b < CNT_SMP) slot_bit = shifted[0];
`else
    sh = pSampleBit - 32'(b);
    shifted = smp >> sh;
    if ((b >= CNT_W'(1)) && (b <= CNT_SMP)) slot_bit = shifted[0];
`endif
  endfunction

  always_ff @(posedge iAudioClk or negedge iAudioRst) begin
    if (!iAudioRst) state_q <= ST_STOP;
    else            state_q <= state_d;
  end

  // Stop requests are only honoured at the frame boundary so the DAC never sees a torn frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP:  if (iEnable) state_d = ST_PRIME;
      ST_PRIME: begin
        if (!iEnable)      state_d = ST_STOP;
        else if (iAudioVd) state_d = ST_RUN;
      end
      ST_RUN:   if (frame_wrap_c && !iEnable) state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // Bit counter, shadow word, request pulse, underrun flag and serial outputs.
  always_comb begin
    req_d     = 1'b0;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    undr_d    = undr_q && !iUnderrunClr;
    unique case (state_q)
      ST_STOP: begin
        bit_cnt_d = '0;
        req_d     = iEnable;
      end
      ST_PRIME: begin
        bit_cnt_d = '0;
        if (iEnable && iAudioVd) shadow_d = stereo_word_t'(iAudioData);
      end
      ST_RUN: begin
        if (fall_tick_c) begin
          bit_cnt_d = frame_wrap_c ? '0 : bit_cnt_q + CNT_W'(1);
          // A stopping frame neither fetches a new word nor reports an underrun.
          if (frame_wrap_c && iEnable) begin
            req_d    = 1'b1;
            shadow_d = iAudioVd ? stereo_word_t'(iAudioData) : '0;
            if (!iAudioVd) undr_d = 1'b1;
          end
        end
      end
      default: bit_cnt_d = '0;
    endcase
    lrck_d  = (state_d == ST_RUN) && (bit_cnt_d >= CNT_SLOT);
    sdata_d = (state_d == ST_RUN) && slot_bit(shadow_d, bit_cnt_d);
  end

  always_ff @(posedge iAudioClk or negedge iAudioRst) begin
    if (!iAudioRst) begin
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      req_q     <= 1'b0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      undr_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      req_q     <= req_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      undr_q    <= undr_d;
    end
  end

  assign oAudioReq  = req_q;
  assign oAudioLRch = lrck_q;
  assign oI2sLrck   = lrck_q;
  assign oI2sSdata  = sdata_q;
  assign oUnderrun  = undr_q;
  assign oI2sBclk   = bclk;

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Bench for audio_i2s_serializer: timeline model of the I2S output plus a simple DAC-side receiver.
module tb_audio_i2s_serializer;

  localparam int D         = 4;
  localparam int FRAME_CLK = 2 * 32 * 2 * D;

  logic        clk = 1'b0;
  logic        rst_n, en, vd, clr;
  logic [31:0] data;
  logic        oAudioReq, oAudioLRch, oI2sBclk, oI2sLrck, oI2sSdata, oUnderrun;

  int total = 0;
  int bad   = 0;

  audio_i2s_serializer dut (
    .iAudioClk    (clk),
    .iAudioRst    (rst_n),
    .iEnable      (en),
    .iAudioData   (data),
    .iAudioVd     (vd),
    .oAudioReq    (oAudioReq),
    .oAudioLRch   (oAudioLRch),
    .oI2sBclk     (oI2sBclk),
    .oI2sLrck     (oI2sLrck),
    .oI2sSdata    (oI2sSdata),
    .oUnderrun    (oUnderrun),
    .iUnderrunClr (clr)
  );

  always #5 clk = ~clk;

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected 64-bit frame, first transmitted bit at [63].
  function automatic logic [63:0] frame_bits(input logic [31:0] w);
`ifdef I2S_LEFT_JUSTIFY_EN
    return {w[31:16], 16'b0, w[15:0], 16'b0};
`else
    return {1'b0, w[31:16], 15'b0, 1'b0, w[15:0], 15'b0};
`endif
  endfunction

  typedef enum int {M_STOP, M_PRIME, M_RUN} mmode_e;
  mmode_e      m_mode = M_STOP;
  int          m_k    = 0;
  logic [31:0] m_word = '0;
  logic        m_und  = 1'b0;
  logic        m_req  = 1'b0;
  logic        m_set;
  logic        e_bclk, e_lrck, e_sdata;
  logic [63:0] m_fb;
  int          m_pos;

  int          cyc = 0;
  int          dut_req_cnt = 0;
  logic        prev_bclk = 1'b0;
  int          last_rise = 0;
  int          rise_cnt = 0;
  int          last_lr_rise = 0;
  int          rx_bclk_per = 0;
  int          rx_lr_per = 0;
  logic        rx_prev = 1'b0;
  int          rx_pos = -1;
  logic [63:0] rx_cur = '0;
  logic [63:0] rx_last = '0;

  // Model advance on each edge, then compare and receive just after it.
  always @(posedge clk) begin
    m_set = 1'b0;
    if (!rst_n) begin
      m_mode = M_STOP;
      m_und  = 1'b0;
      m_req  = 1'b0;
    end else begin
      m_req = 1'b0;
      case (m_mode)
        M_STOP: if (en) begin m_mode = M_PRIME; m_req = 1'b1; end
        M_PRIME: begin
          if (!en) m_mode = M_STOP;
          else if (vd) begin m_mode = M_RUN; m_k = 0; m_word = data; end
        end
        default: begin
          if (m_k % FRAME_CLK == FRAME_CLK - 1) begin
            if (!en) m_mode = M_STOP;
            else begin
              m_req  = 1'b1;
              m_word = vd ? data : 32'h0;
              m_set  = !vd;
            end
          end
          m_k++;
        end
      endcase
      m_und = m_set | (m_und & ~clr);
    end
    if (m_mode == M_RUN) begin
      m_pos   = (m_k / (2 * D)) % 64;
      m_fb    = frame_bits(m_word);
      e_bclk  = ((m_k / D) % 2) == 1;
      e_lrck  = m_pos >= 32;
      e_sdata = m_fb[6'(63 - m_pos)];
    end else begin
      e_bclk = 1'b0; e_lrck = 1'b0; e_sdata = 1'b0;
    end
    cyc++;
    #1;
    check_b("bclk", oI2sBclk, e_bclk);
    check_b("lrck", oI2sLrck, e_lrck);
    check_b("lrch", oAudioLRch, e_lrck);
    check_b("sdata", oI2sSdata, e_sdata);
    check_b("req", oAudioReq, m_req);
    check_b("underrun", oUnderrun, m_und);
    if (oAudioReq) dut_req_cnt++;
    if (oI2sBclk && !prev_bclk) begin
      rx_bclk_per = cyc - last_rise;
      last_rise   = cyc;
      rise_cnt++;
      if (oI2sLrck && !rx_prev) begin
        rx_pos       = 32;
        rx_lr_per    = rise_cnt - last_lr_rise;
        last_lr_rise = rise_cnt;
      end else if (!oI2sLrck && rx_prev) begin
        rx_last = rx_cur;
        rx_pos  = 0;
      end else begin
        rx_pos++;
      end
      if (rx_pos >= 0 && rx_pos < 64) rx_cur[6'(63 - rx_pos)] = oI2sSdata;
      rx_prev = oI2sLrck;
    end
    prev_bclk = oI2sBclk;
  end

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oAudioReq && n < 1200);
    if (!oAudioReq) begin
      total++;
      bad++;
      $display("FAIL wait_req_%s: no request after %0d cycles", tag, n);
    end
  endtask

  logic [63:0] exp_frame;
  logic [31:0] w5;
  int          r0;
  logic        bclk_seen;

  initial begin
    rst_n = 1'b0; en = 1'b0; vd = 1'b0; clr = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    check_b("rst_bclk", oI2sBclk, 1'b0);
    check_b("rst_sdata", oI2sSdata, 1'b0);
    check_b("rst_req", oAudioReq, 1'b0);
    rst_n = 1'b1;

    // Fixed word, continuous valid data.
    rx_pos = -1;
`ifdef I2S_LEFT_JUSTIFY_EN
    data = 32'h8000_0001; exp_frame = 64'h8000_0000_0001_0000;
`else
    data = 32'hA5A5_3C3C; exp_frame = 64'h52D2_8000_1E1E_0000;
`endif
    vd = 1'b1; en = 1'b1;
    @(negedge clk);
    check_b("prime_req", oAudioReq, 1'b1);
    r0 = dut_req_cnt;
    repeat (1540) @(negedge clk);
    check_w("req_3_frames", 64'(dut_req_cnt - r0), 64'd3);
    check_w("frame_bits", rx_last, exp_frame);
    check_w("bclk_period", 64'(rx_bclk_per), 64'd8);
    check_w("lrck_period", 64'(rx_lr_per), 64'd64);

    // Underrun frame, sticky flag, clear, and clear losing to a new underrun.
    wait_req("u0");
    vd = 1'b0; data = $urandom;
    wait_req("u1");
    check_b("und_set", oUnderrun, 1'b1);
    vd = 1'b1; data = $urandom;
    wait_req("u2");
    repeat (20) @(negedge clk);
    check_w("und_frame_zero", rx_last, 64'h0);
    check_b("und_held", oUnderrun, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_b("und_cleared", oUnderrun, 1'b0);
    wait_req("u3");
    repeat (511) @(negedge clk);
    vd = 1'b0; clr = 1'b1;
    @(negedge clk);
    vd = 1'b1; clr = 1'b0;
    check_b("und_set_wins", oUnderrun, 1'b1);
    check_b("latch_req", oAudioReq, 1'b1);

    // Random words, occasional underruns and clears.
    for (int f = 0; f < 6; f++) begin
      wait_req("rnd");
      data = $urandom;
      vd   = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 300)) @(negedge clk);
      clr = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      clr = 1'b0;
    end

    // Asynchronous reset mid-frame with underrun pending.
    wait_req("r0");
    vd = 1'b0;
    wait_req("r1");
    vd = 1'b1;
    repeat (150) @(negedge clk);
    check_b("pre_rst_und", oUnderrun, 1'b1);
    rst_n = 1'b0;
    #1;
    check_b("arst_bclk", oI2sBclk, 1'b0);
    check_b("arst_lrck", oI2sLrck, 1'b0);
    check_b("arst_sdata", oI2sSdata, 1'b0);
    check_b("arst_und", oUnderrun, 1'b0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Prime with data late: BCLK idle until the first valid word.
    rx_pos = -1; vd = 1'b0; en = 1'b1;
    @(negedge clk);
    check_b("prime2_req", oAudioReq, 1'b1);
    bclk_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      bclk_seen = bclk_seen | oI2sBclk;
    end
    check_b("prime_bclk_idle", bclk_seen, 1'b0);
    w5 = $urandom; data = w5; vd = 1'b1;
    repeat (532) @(negedge clk);
`ifdef I2S_LEFT_JUSTIFY_EN
    check_w("prime_left", 64'(rx_last[63:48]), 64'(w5[31:16]));
`else
    check_w("prime_left", 64'(rx_last[62:47]), 64'(w5[31:16]));
    check_b("prime_bit0", rx_last[63], 1'b0);
`endif

    // Disable mid-frame: the frame completes, then the block stops.
    wait_req("d0");
    repeat (85) @(negedge clk);
    en = 1'b0;
    repeat (315) @(negedge clk);
    check_b("dis_still_running", oI2sLrck, 1'b1);
    repeat (120) @(negedge clk);
    check_b("dis_bclk_low", oI2sBclk, 1'b0);
    check_b("dis_lrck_low", oI2sLrck, 1'b0);
    r0 = dut_req_cnt;
    repeat (600) @(negedge clk);
    check_w("dis_no_req", 64'(dut_req_cnt - r0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
